// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: CPU stores (via in-order FIFO) vs host stream, CPU priority with bounded burst.
// Optional FB_ARB_PERF_EN adds 32-bit grant/stall performance counters.
module fb_write_arbiter #(
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 16,
  parameter int CPU_FIFO_DEPTH = 4,
  parameter int MAX_CPU_BURST  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_fb_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_stall,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_wdata,
`ifdef FB_ARB_PERF_EN
  output logic [31:0]       perf_cpu_writes,
  output logic [31:0]       perf_host_writes,
  output logic [31:0]       perf_stall_cycles,
`endif
  output logic              idle
);

  localparam int PTR_W   = $clog2(CPU_FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int BURST_W = $clog2(MAX_CPU_BURST + 1);

  logic [ADDR_W-1:0]  addr_mem_q [CPU_FIFO_DEPTH];
  logic [DATA_W-1:0]  data_mem_q [CPU_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic [DATA_W-1:0]  fb_wdata_q, fb_wdata_d;

  logic enq, deq, cpu_req, burst_at_max;
  logic grant_cpu, grant_host;

  assign cpu_stall    = (count_q == CNT_W'(CPU_FIFO_DEPTH));
  assign enq          = cpu_fb_write && !cpu_stall;
  assign cpu_req      = (count_q != '0);
  assign burst_at_max = (burst_q == BURST_W'(MAX_CPU_BURST));
  assign deq          = grant_cpu;

  // Reset gates the grants so host_ready never pulses while state is being cleared.
  always_comb begin
    grant_cpu  = 1'b0;
    grant_host = 1'b0;
    if (!reset) begin
      if (cpu_req && host_valid) begin
        grant_host = burst_at_max;
        grant_cpu  = !burst_at_max;
      end else begin
        grant_cpu  = cpu_req;
        grant_host = host_valid;
      end
    end
  end

  assign host_ready = grant_host;

  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    burst_d = burst_q;
    if (!host_valid || grant_host) begin
      burst_d = '0;
    end else if (grant_cpu && !burst_at_max) begin
      burst_d = burst_q + BURST_W'(1);
    end
  end

  always_comb begin
    fb_we_d    = grant_cpu | grant_host;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    if (grant_host) begin
      fb_addr_d  = host_addr;
      fb_wdata_d = host_data;
    end else if (grant_cpu) begin
      fb_addr_d  = addr_mem_q[rd_ptr_q];
      fb_wdata_d = data_mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      burst_q    <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      burst_q    <= burst_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
    end
  end

  // Storage is not reset; occupancy is tracked solely by count_q and the pointers.
  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      addr_mem_q[wr_ptr_q] <= cpu_addr;
      data_mem_q[wr_ptr_q] <= cpu_data;
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign idle     = !cpu_req && !fb_we_q && !host_valid;

`ifdef FB_ARB_PERF_EN
  logic [31:0] perf_cpu_q, perf_host_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cpu_q   <= '0;
      perf_host_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (grant_cpu)                  perf_cpu_q   <= perf_cpu_q + 32'd1;
      if (grant_host)                 perf_host_q  <= perf_host_q + 32'd1;
      if (cpu_fb_write && cpu_stall)  perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cpu_writes   = perf_cpu_q;
  assign perf_host_writes  = perf_host_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: vector table plus burst/stall and mid-operation reset sequences.
module tb_fb_write_arbiter;

  localparam int BURST = 8;

  logic        clk;
  logic        reset;
  logic        cpu_fb_write;
  logic [16:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_stall;
  logic        host_valid;
  logic [16:0] host_addr;
  logic [15:0] host_data;
  logic        host_ready;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [15:0] fb_wdata;
  logic        idle;
`ifdef FB_ARB_PERF_EN
  logic [31:0] perf_cpu_writes, perf_host_writes, perf_stall_cycles;
`endif

  fb_write_arbiter #(
    .ADDR_W(17), .DATA_W(16), .CPU_FIFO_DEPTH(4), .MAX_CPU_BURST(BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_fb_write(cpu_fb_write), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_stall(cpu_stall),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
`ifdef FB_ARB_PERF_EN
    .perf_cpu_writes(perf_cpu_writes), .perf_host_writes(perf_host_writes),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rst, cw;
    logic [16:0] ca;
    logic [15:0] cd;
    logic        hv;
    logic [16:0] ha;
    logic [15:0] hd;
    logic        e_stall, e_hrdy, e_we;
    logic [16:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_idle;
  } vec_t;

  function automatic vec_t mk(input int rst, cw, ca, cd, hv, ha, hd,
                              input int s, r, w, a, d, idl);
    vec_t v;
    v.rst = rst[0]; v.cw = cw[0]; v.ca = 17'(ca); v.cd = 16'(cd);
    v.hv = hv[0]; v.ha = 17'(ha); v.hd = 16'(hd);
    v.e_stall = s[0]; v.e_hrdy = r[0]; v.e_we = w[0];
    v.e_addr = 17'(a); v.e_wdata = 16'(d); v.e_idle = idl[0];
    return v;
  endfunction

  vec_t vt [22];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int seq, hcnt, exp_cpu;
    logic        nxt_we;
    logic [15:0] nxt_dat;
    logic        stall_seen, slot_host;

    //          rst cw ca      cd      hv ha       hd       stall rdy we addr     wdata   idle
    vt[0]  = mk(1, 0, 0,      0,      0, 0,       0,       0, 0, 0, 0,       0,      1);
    vt[1]  = mk(0, 1, 'h10,   'hF800, 0, 0,       0,       0, 0, 0, 0,       0,      1);
    vt[2]  = mk(0, 0, 0,      0,      0, 0,       0,       0, 0, 0, 0,       0,      0);
    vt[3]  = mk(0, 0, 0,      0,      0, 0,       0,       0, 0, 1, 'h10,    'hF800, 0);
    vt[4]  = mk(0, 0, 0,      0,      0, 0,       0,       0, 0, 0, 'h10,    'hF800, 1);
    vt[5]  = mk(0, 0, 0,      0,      1, 'h1234,  'hABCD,  0, 1, 0, 'h10,    'hF800, 0);
    vt[6]  = mk(0, 0, 0,      0,      0, 0,       0,       0, 0, 1, 'h1234,  'hABCD, 0);
    vt[7]  = mk(0, 0, 0,      0,      0, 0,       0,       0, 0, 0, 'h1234,  'hABCD, 1);
    vt[8]  = mk(0, 1, 'h20,   'h0001, 0, 0,       0,       0, 0, 0, 'h1234,  'hABCD, 1);
    vt[9]  = mk(0, 0, 0,      0,      1, 'h55,    'h5555,  0, 0, 0, 'h1234,  'hABCD, 0);
    vt[10] = mk(0, 0, 0,      0,      1, 'h55,    'h5555,  0, 1, 1, 'h20,    'h0001, 0);
    vt[11] = mk(0, 0, 0,      0,      0, 0,       0,       0, 0, 1, 'h55,    'h5555, 0);
    vt[12] = mk(0, 0, 0,      0,      0, 0,       0,       0, 0, 0, 'h55,    'h5555, 1);
    vt[13] = mk(0, 1, 'h101,  1,      0, 0,       0,       0, 0, 0, 'h55,    'h5555, 1);
    vt[14] = mk(0, 1, 'h102,  2,      0, 0,       0,       0, 0, 0, 'h55,    'h5555, 0);
    vt[15] = mk(0, 1, 'h103,  3,      0, 0,       0,       0, 0, 1, 'h101,   1,      0);
    vt[16] = mk(0, 1, 'h104,  4,      0, 0,       0,       0, 0, 1, 'h102,   2,      0);
    vt[17] = mk(0, 1, 'h105,  5,      0, 0,       0,       0, 0, 1, 'h103,   3,      0);
    vt[18] = mk(0, 1, 'h106,  6,      0, 0,       0,       0, 0, 1, 'h104,   4,      0);
    vt[19] = mk(0, 0, 0,      0,      0, 0,       0,       0, 0, 1, 'h105,   5,      0);
    vt[20] = mk(0, 0, 0,      0,      0, 0,       0,       0, 0, 1, 'h106,   6,      0);
    vt[21] = mk(0, 0, 0,      0,      0, 0,       0,       0, 0, 0, 'h106,   6,      1);

    reset = 1'b1; cpu_fb_write = 1'b0; cpu_addr = '0; cpu_data = '0;
    host_valid = 1'b0; host_addr = '0; host_data = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      reset = vt[i].rst; cpu_fb_write = vt[i].cw; cpu_addr = vt[i].ca; cpu_data = vt[i].cd;
      host_valid = vt[i].hv; host_addr = vt[i].ha; host_data = vt[i].hd;
      #1;
      chk($sformatf("vec%0d", i),
          64'({cpu_stall, host_ready, fb_we, fb_addr, fb_wdata, idle}),
          64'({vt[i].e_stall, vt[i].e_hrdy, vt[i].e_we, vt[i].e_addr, vt[i].e_wdata, vt[i].e_idle}));
      @(posedge clk);
      #1;
    end

    // Sustained contention: 8 CPU writes then 1 host write; FIFO creeps up to full.
    reset = 1'b1; cpu_fb_write = 1'b0; host_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seq = 1; hcnt = 0; exp_cpu = 1; nxt_we = 1'b0; nxt_dat = 16'h0;
    for (int t = 0; t <= 38; t++) begin
      stall_seen = cpu_stall;
      if (t == 38) begin
        reset = 1'b1; cpu_fb_write = 1'b0; host_valid = 1'b0;
      end else begin
        cpu_fb_write = 1'b1;
        host_valid   = (t >= 1);
        cpu_data     = stall_seen ? 16'hDEAD : 16'(seq);
        cpu_addr     = {1'b0, cpu_data};
        host_data    = 16'hA000 + 16'(hcnt);
        host_addr    = 17'h1F000 + 17'(hcnt);
      end
      #1;
      chk($sformatf("burst_out t%0d", t), 64'({fb_we, fb_wdata}), 64'({nxt_we, nxt_dat}));
      slot_host = (t >= BURST + 1) && (t % (BURST + 1) == 0);
      if (t >= 1 && t <= 37) begin
        chk($sformatf("burst_host_ready t%0d", t), 64'(host_ready), 64'(slot_host));
        chk($sformatf("burst_stall t%0d", t), 64'(cpu_stall), 64'(t == 28 || t == 37));
        nxt_we = 1'b1;
        if (slot_host) begin
          nxt_dat = 16'hA000 + 16'(hcnt);
          hcnt++;
        end else begin
          nxt_dat = 16'(exp_cpu);
          exp_cpu++;
        end
      end else begin
        nxt_we = 1'b0;
      end
      if (t <= 37 && !stall_seen) seq++;
`ifdef FB_ARB_PERF_EN
      if (t == 38) begin
        chk("perf_cpu", 64'(perf_cpu_writes), 64'd33);
        chk("perf_host", 64'(perf_host_writes), 64'd4);
        chk("perf_stall", 64'(perf_stall_cycles), 64'd2);
      end
`endif
      @(posedge clk);
      #1;
    end

    // Reset above landed with 3 entries queued; none of them may ever be written.
    reset = 1'b0; cpu_fb_write = 1'b0; host_valid = 1'b0;
    for (int g = 0; g < 8; g++) begin
      #1;
      chk($sformatf("post_reset g%0d", g),
          64'({fb_we, fb_addr, fb_wdata, idle, cpu_stall, host_ready}),
          64'({1'b0, 17'h0, 16'h0, 1'b1, 1'b0, 1'b0}));
`ifdef FB_ARB_PERF_EN
      if (g == 0) begin
        chk("perf_reset",
            64'({perf_cpu_writes[15:0], perf_host_writes[15:0], perf_stall_cycles[15:0]}),
            64'(0));
      end
`endif
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
